// File: rtl/jogo_rondas.sv
// jogo_rondas: sequential round engine for the N-player pedra/papel/tesoura
// betting game. Keeps per-player balances across rounds, carries the pot on
// ties and splits it among winners with a restoring divider (one quotient bit
// per cycle).
//
// Handshake: inicio is a start request that is accepted only on a cycle where
// ocupado is low (IDLE); ocupado stays high until the round is finished, and
// fim pulses for exactly one cycle when the round's results become visible.
// nova_partida is likewise accepted only while ocupado is low, and takes
// priority over inicio.
module jogo_rondas #(
    parameter int N_JOG     = 4,
    parameter int W_APOSTA  = 7,
    parameter int W_SALDO   = 10,
    parameter int SALDO_INI = 200,
    parameter int W_RONDA   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inicio,
    input  logic                      nova_partida,
    input  logic [2*N_JOG-1:0]        jogadas,
    input  logic [W_APOSTA*N_JOG-1:0] apostas,
    output logic                      ocupado,
    output logic                      fim,
    output logic [N_JOG-1:0]          vencedores,
    output logic                      empate,
    output logic [W_SALDO*N_JOG-1:0]  saldos,
    output logic [W_SALDO-1:0]        pote,
    output logic [W_RONDA-1:0]        ronda,
    output logic [2:0]                estado
);

    // Winner count and divider remainder never exceed N_JOG.
    localparam int W_K   = $clog2(N_JOG + 1);
    localparam int W_CNT = $clog2(W_SALDO);
    localparam logic [W_SALDO-1:0] INI     = W_SALDO'(SALDO_INI);
    localparam logic [W_CNT-1:0]   CNT_ULT = W_CNT'(W_SALDO - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURA = 3'd1,
        AVALIA  = 3'd2,
        DIVIDE  = 3'd3,
        PAGA    = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t st, st_nx;

    // Latched round inputs
    logic [2*N_JOG-1:0]        jog_r;
    logic [W_APOSTA*N_JOG-1:0] apo_r;

    // Game state
    logic [W_SALDO-1:0] saldo_r [N_JOG];
    logic [W_SALDO-1:0] pote_r;
    logic [W_RONDA-1:0] ronda_r;
    logic [N_JOG-1:0]   venc_r;
    logic               emp_r;

    // Round evaluation / divider state
    logic [N_JOG-1:0]   mask_r;
    logic [W_K-1:0]     k_r;
    logic [W_SALDO-1:0] dvd_r;   // dividend shifting out, quotient shifting in
    logic [W_K-1:0]     rem_r;
    logic [W_CNT-1:0]   cnt_r;

    // Combinational evaluation of the latched round
    logic [N_JOG-1:0]   part;
    logic [N_JOG-1:0]   mask;
    logic [W_SALDO-1:0] eff [N_JOG];
    logic [W_SALDO-1:0] soma;
    logic [2:0]         simb;
    logic [W_K-1:0]     n_part;
    logic [W_K-1:0]     k_c;
    logic [1:0]         sim_ven;
    logic               dois;
    logic               valida;

    // Divider step
    logic [W_K:0]       rem_sh;
    logic               ge;
    logic [W_K-1:0]     rem_nx;

    // Participants, effective bets, symbol set and winner mask of the latched round
    always_comb begin
        part    = '0;
        mask    = '0;
        soma    = '0;
        simb    = '0;
        n_part  = '0;
        k_c     = '0;
        sim_ven = 2'd0;
        dois    = 1'b0;
        for (int i = 0; i < N_JOG; i++) begin
            eff[i] = '0;
        end
        for (int i = 0; i < N_JOG; i++) begin
            part[i] = (jog_r[2*i +: 2] != 2'd3) && (saldo_r[i] != '0);
            if (part[i]) begin
                // A bet larger than the balance is clipped to the balance.
                if (W_SALDO'(apo_r[W_APOSTA*i +: W_APOSTA]) < saldo_r[i])
                    eff[i] = W_SALDO'(apo_r[W_APOSTA*i +: W_APOSTA]);
                else
                    eff[i] = saldo_r[i];
                simb   = simb | (3'b001 << jog_r[2*i +: 2]);
                n_part = n_part + 1'b1;
                soma   = soma + eff[i];
            end
        end
        // With exactly two symbols the winner is fixed by the game cycle.
        case (simb)
            3'b011: begin sim_ven = 2'd1; dois = 1'b1; end  // papel beats pedra
            3'b110: begin sim_ven = 2'd2; dois = 1'b1; end  // tesoura beats papel
            3'b101: begin sim_ven = 2'd0; dois = 1'b1; end  // pedra beats tesoura
            default: begin sim_ven = 2'd0; dois = 1'b0; end
        endcase
        valida = (n_part >= W_K'(2));
        for (int i = 0; i < N_JOG; i++) begin
            if (part[i] && (jog_r[2*i +: 2] == sim_ven)) begin
                mask[i] = 1'b1;
                k_c     = k_c + 1'b1;
            end
        end
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem_r, dvd_r[W_SALDO-1]};
        ge     = (rem_sh >= {1'b0, k_r});
        if (ge)
            rem_nx = W_K'(rem_sh - {1'b0, k_r});
        else
            rem_nx = W_K'(rem_sh);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= IDLE;
        else
            st <= st_nx;
    end

    // Next-state logic
    always_comb begin
        st_nx = st;
        case (st)
            IDLE: begin
                if (!nova_partida && inicio)
                    st_nx = CAPTURA;
            end
            CAPTURA: st_nx = AVALIA;
            AVALIA: begin
                if (valida && dois)
                    st_nx = DIVIDE;
                else
                    st_nx = FIM;
            end
            DIVIDE: begin
                if (cnt_r == CNT_ULT)
                    st_nx = PAGA;
            end
            PAGA:    st_nx = FIM;
            FIM:     st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    // Datapath: input capture, deductions, division, payout and round count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jog_r   <= '0;
            apo_r   <= '0;
            for (int i = 0; i < N_JOG; i++) begin
                saldo_r[i] <= INI;
            end
            pote_r  <= '0;
            ronda_r <= '0;
            venc_r  <= '0;
            emp_r   <= 1'b0;
            mask_r  <= '0;
            k_r     <= '0;
            dvd_r   <= '0;
            rem_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (nova_partida) begin
                        for (int i = 0; i < N_JOG; i++) begin
                            saldo_r[i] <= INI;
                        end
                        pote_r  <= '0;
                        ronda_r <= '0;
                    end
                end
                CAPTURA: begin
                    jog_r <= jogadas;
                    apo_r <= apostas;
                end
                AVALIA: begin
                    if (valida) begin
                        for (int i = 0; i < N_JOG; i++) begin
                            saldo_r[i] <= saldo_r[i] - eff[i];
                        end
                        pote_r <= pote_r + soma;
                    end
                    if (valida && dois) begin
                        mask_r <= mask;
                        k_r    <= k_c;
                        dvd_r  <= pote_r + soma;
                        rem_r  <= '0;
                        cnt_r  <= '0;
                    end else begin
                        // Void round or tie: results are known now.
                        venc_r <= '0;
                        emp_r  <= 1'b1;
                    end
                end
                DIVIDE: begin
                    rem_r <= rem_nx;
                    dvd_r <= {dvd_r[W_SALDO-2:0], ge};
                    cnt_r <= cnt_r + 1'b1;
                end
                PAGA: begin
                    for (int i = 0; i < N_JOG; i++) begin
                        if (mask_r[i])
                            saldo_r[i] <= saldo_r[i] + dvd_r;
                    end
                    pote_r <= W_SALDO'(rem_r);
                    venc_r <= mask_r;
                    emp_r  <= 1'b0;
                end
                FIM: begin
                    ronda_r <= ronda_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output packing
    always_comb begin
        saldos = '0;
        for (int i = 0; i < N_JOG; i++) begin
            saldos[W_SALDO*i +: W_SALDO] = saldo_r[i];
        end
        ocupado    = (st != IDLE);
        fim        = (st == FIM);
        vencedores = venc_r;
        empate     = emp_r;
        pote       = pote_r;
        ronda      = ronda_r;
        estado     = st;
    end

endmodule
